// File: rtl/matvec_core_pkg.sv
// Shared constants for the matrix-vector core and fetch engine: geometry, stream depths,
// accumulator width derivation and the core state enum.
package matvec_core_pkg;

  localparam int unsigned MAT_ROWS       = 4;
  localparam int unsigned MAT_COLS       = 4;
  localparam int unsigned MAT_DATA_WIDTH = 8;
  localparam int unsigned W_DEPTH        = MAT_ROWS * MAT_COLS;
  localparam int unsigned X_DEPTH        = MAT_COLS;

  // Counter width that stays legal (>= 1 bit) for depth-1 ranges.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Wide enough that COLS full-scale products never overflow.
  function automatic int unsigned acc_width(input int unsigned dw, input int unsigned cols);
    return 2 * dw + $clog2(cols);
  endfunction

  typedef enum logic [1:0] {
    StLoadW,
    StLoadX,
    StCompute,
    StOutput
  } core_state_e;

endpackage

// File: rtl/matvec_core_mac_unit.sv
// Registered signed multiply-accumulate. sum_o is the value the accumulator takes on an
// enabled cycle, so the final sum can be captured in the same cycle as the last MAC.
module mac_unit #(
  parameter int unsigned DataWidth = 8,
  parameter int unsigned AccWidth  = 18
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        clr_i,
  input  logic                        en_i,
  input  logic signed [DataWidth-1:0] a_i,
  input  logic signed [DataWidth-1:0] b_i,
  output logic signed [AccWidth-1:0]  sum_o
);

  logic signed [2*DataWidth-1:0] prod;
  logic signed [AccWidth-1:0]    acc_q;

  assign prod  = a_i * b_i;
  assign sum_o = acc_q + AccWidth'(prod);

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= sum_o;
    end
  end

endmodule

// File: rtl/matvec_core.sv
// Matrix-vector core: loads ROWS*COLS weights then COLS activations from the source stream,
// computes y = W*x one MAC per cycle and streams out ROWS signed results.
module matvec_core
  import matvec_core_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = MAT_DATA_WIDTH,
  parameter int unsigned ROWS       = MAT_ROWS,
  parameter int unsigned COLS       = MAT_COLS,
  parameter int unsigned ACC_WIDTH  = acc_width(DATA_WIDTH, COLS)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  src_vld_i,
  output logic                  src_rdy_o,
  input  logic [DATA_WIDTH-1:0] src_data_i,
  output logic                  res_vld_o,
  input  logic                  res_rdy_i,
  output logic [ACC_WIDTH-1:0]  res_data_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int unsigned Depth = ROWS * COLS;
  localparam int unsigned IdxW  = clog2_min1(Depth);
  localparam int unsigned RowW  = clog2_min1(ROWS);
  localparam int unsigned ColW  = clog2_min1(COLS);

  core_state_e state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [RowW-1:0] row_q, row_d;
  logic [ColW-1:0] col_q, col_d;
  logic            res_vld_q, res_vld_d;
  logic            done_q, done_d;
  logic [ACC_WIDTH-1:0] res_data_q, res_data_d;

  logic signed [DATA_WIDTH-1:0] w_mem [Depth];
  logic signed [DATA_WIDTH-1:0] x_mem [COLS];

  logic                        w_we, x_we, mac_clr, mac_en;
  logic [IdxW-1:0]             w_addr;
  logic signed [ACC_WIDTH-1:0] mac_sum;

  assign w_addr = IdxW'(row_q) * IdxW'(COLS) + IdxW'(col_q);

  mac_unit #(
    .DataWidth(DATA_WIDTH),
    .AccWidth (ACC_WIDTH)
  ) u_mac (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .clr_i(mac_clr),
    .en_i (mac_en),
    .a_i  (w_mem[w_addr]),
    .b_i  (x_mem[col_q]),
    .sum_o(mac_sum)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    row_d      = row_q;
    col_d      = col_q;
    res_vld_d  = res_vld_q;
    res_data_d = res_data_q;
    done_d     = 1'b0;
    w_we       = 1'b0;
    x_we       = 1'b0;
    mac_clr    = 1'b0;
    mac_en     = 1'b0;
    unique case (state_q)
      StLoadW: begin
        if (src_vld_i) begin
          w_we = 1'b1;
          if (idx_q == IdxW'(Depth - 1)) begin
            idx_d   = '0;
            state_d = StLoadX;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end
      StLoadX: begin
        if (src_vld_i) begin
          x_we = 1'b1;
          if (idx_q == IdxW'(COLS - 1)) begin
            idx_d   = '0;
            row_d   = '0;
            col_d   = '0;
            mac_clr = 1'b1;
            state_d = StCompute;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end
      StCompute: begin
        mac_en = 1'b1;
        if (col_q == ColW'(COLS - 1)) begin
          res_data_d = mac_sum;
          res_vld_d  = 1'b1;
          state_d    = StOutput;
        end else begin
          col_d = col_q + ColW'(1);
        end
      end
      StOutput: begin
        if (res_rdy_i) begin
          res_vld_d = 1'b0;
          if (row_q == RowW'(ROWS - 1)) begin
            done_d  = 1'b1;
            state_d = StLoadW;
          end else begin
            row_d   = row_q + RowW'(1);
            col_d   = '0;
            mac_clr = 1'b1;
            state_d = StCompute;
          end
        end
      end
      default: state_d = StLoadW;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StLoadW;
      idx_q      <= '0;
      row_q      <= '0;
      col_q      <= '0;
      res_vld_q  <= 1'b0;
      res_data_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      row_q      <= row_d;
      col_q      <= col_d;
      res_vld_q  <= res_vld_d;
      res_data_q <= res_data_d;
      done_q     <= done_d;
    end
  end

  // Operand storage is deliberately not reset; a fresh run overwrites every entry.
  always_ff @(posedge clk_i) begin
    if (w_we) w_mem[idx_q] <= src_data_i;
    if (x_we) x_mem[ColW'(idx_q)] <= src_data_i;
  end

  assign src_rdy_o  = (state_q == StLoadW) || (state_q == StLoadX);
  assign busy_o     = !((state_q == StLoadW) && (idx_q == '0));
  assign res_vld_o  = res_vld_q;
  assign res_data_o = res_data_q;
  assign done_o     = done_q;

endmodule
